// File: rtl/ebus_diag_pkg.sv
// Shared types and helpers for the EBUS diagnostic-function sequencer.
package ebus_diag_pkg;

  localparam int DIAG_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } diagSeqState_t;

  typedef bit [0:6] diagFunc_t;

  // Diag codes 100-177 (ds[0] set) are reads; 000-077 are writes.
  function automatic logic isReadFunc(input diagFunc_t f);
    return f[0];
  endfunction

endpackage

// File: rtl/diag_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer moves
// to the other requester whenever a grant is accepted.
module diag_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:1] i_valid,
  input  logic       i_accept,
  output logic [0:1] o_grant
);

  // r_ptr = 0: requester 0 has priority; r_ptr = 1: requester 1 has priority.
  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    if (!r_ptr) begin
      o_grant[0] = i_valid[0];
      o_grant[1] = i_valid[1] & ~i_valid[0];
    end else begin
      o_grant[1] = i_valid[1];
      o_grant[0] = i_valid[0] & ~i_valid[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_accept && (|o_grant)) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/ebus_diag_seq.sv
// EBUS diag-function sequencer: arbitrates two requesters and drives ds/data/strobe
// with programmable setup, strobe and hold. Optional parity check: EBUS_DIAG_PARITY_EN.
module ebus_diag_seq
  import ebus_diag_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:1]  req_valid,
  input  logic [0:6]  req_func0,
  input  logic [0:6]  req_func1,
  input  logic [0:35] req_wdata0,
  input  logic [0:35] req_wdata1,
  output logic [0:1]  req_ready,
  output logic [0:1]  resp_valid,
  output logic [0:35] resp_data,
  output logic        resp_par_err,
  output logic        busy,
  output logic [0:6]  ebus_ds,
  output logic        ebus_diag_strobe,
  output logic        ebus_drive,
  output logic [0:35] ebus_data_out,
  input  logic [0:35] ebus_data_in,
  input  logic        ebus_par_in
);

  localparam logic [DIAG_CNT_W-1:0] SETUP_LD  = DIAG_CNT_W'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
  localparam logic [DIAG_CNT_W-1:0] STROBE_LD = DIAG_CNT_W'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
  localparam logic [DIAG_CNT_W-1:0] HOLD_LD   = DIAG_CNT_W'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);

  diagSeqState_t         r_state, w_state_next;
  logic [DIAG_CNT_W-1:0] r_cnt, w_cnt_next;
  logic                  r_start, w_start_next;
  logic                  w_accept;
  logic [0:1]            w_grant;

  diagFunc_t             r_func;
  logic [0:35]           r_wdata;
  logic                  r_owner;
  logic [0:35]           r_rdata;

  logic [0:1]            r_req_ready;
  logic [0:1]            r_resp_valid;
  logic [0:35]           r_resp_data;
  logic                  r_busy;
  logic [0:6]            r_ds;
  logic                  r_strobe;
  logic                  r_drive;
  logic [0:35]           r_data_out;

  logic                  w_phase_next;
  logic                  w_done_next;
  logic                  w_cap_en;
  logic [0:35]           w_rd_src;

  diag_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  // r_start marks the accept cycle (req_ready high, ds still 0) so the grant
  // is separated from the first SETUP cycle without adding a visible state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start_next = 1'b0;
    w_accept     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_start) begin
          if (SETUP_CYC == 0) begin
            w_state_next = ST_STROBE;
            w_cnt_next   = STROBE_LD;
          end else begin
            w_state_next = ST_SETUP;
            w_cnt_next   = SETUP_LD;
          end
        end else if (|req_valid) begin
          w_accept     = 1'b1;
          w_start_next = 1'b1;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state_next = ST_STROBE;
          w_cnt_next   = STROBE_LD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          if (HOLD_CYC == 0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_HOLD;
            w_cnt_next   = HOLD_LD;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
        if (|req_valid) begin
          w_accept     = 1'b1;
          w_start_next = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_start <= w_start_next;
    end
  end

  assign w_phase_next = (w_state_next == ST_SETUP) || (w_state_next == ST_STROBE) ||
                        (w_state_next == ST_HOLD);
  assign w_done_next  = (w_state_next == ST_DONE);
  assign w_cap_en     = (r_state == ST_STROBE) && (r_cnt == '0);
  // With no hold phase the capture and completion share one edge, so bypass.
  assign w_rd_src     = (r_state == ST_STROBE) ? ebus_data_in : r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func       <= '0;
      r_wdata      <= '0;
      r_owner      <= 1'b0;
      r_rdata      <= '0;
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_busy       <= 1'b0;
      r_ds         <= '0;
      r_strobe     <= 1'b0;
      r_drive      <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_req_ready <= w_accept ? w_grant : 2'b00;
      if (w_accept) begin
        r_func  <= w_grant[0] ? req_func0 : req_func1;
        r_wdata <= w_grant[0] ? req_wdata0 : req_wdata1;
        r_owner <= w_grant[1];
      end
      if (w_cap_en) begin
        r_rdata <= ebus_data_in;
      end
      r_ds       <= w_phase_next ? r_func : '0;
      r_drive    <= w_phase_next && !isReadFunc(r_func);
      r_data_out <= (w_phase_next && !isReadFunc(r_func)) ? r_wdata : '0;
      r_strobe   <= (w_state_next == ST_STROBE);
      r_busy     <= (w_state_next != ST_IDLE);
      r_resp_valid <= w_done_next ? {~r_owner, r_owner} : 2'b00;
      if (w_done_next && isReadFunc(r_func)) begin
        r_resp_data <= w_rd_src;
      end
    end
  end

`ifdef EBUS_DIAG_PARITY_EN
  logic r_par_cap;
  logic r_par_err;
  logic w_par_src;

  assign w_par_src = (r_state == ST_STROBE) ? ebus_par_in : r_par_cap;

  // Odd parity over data plus parity bit is the good case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_cap <= 1'b0;
      r_par_err <= 1'b0;
    end else begin
      if (w_cap_en) begin
        r_par_cap <= ebus_par_in;
      end
      r_par_err <= w_done_next && isReadFunc(r_func) && ~(^{w_rd_src, w_par_src});
    end
  end

  assign resp_par_err = r_par_err;
`else
  logic w_unused_par;
  assign w_unused_par = ebus_par_in;
  assign resp_par_err = 1'b0;
`endif

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_data        = r_resp_data;
  assign busy             = r_busy;
  assign ebus_ds          = r_ds;
  assign ebus_diag_strobe = r_strobe;
  assign ebus_drive       = r_drive;
  assign ebus_data_out    = r_data_out;

endmodule

// File: tb/tb_ebus_diag_seq.sv
// Directed bench for ebus_diag_seq: default-timing instance plus a 0/1/0 timing instance.
module tb_ebus_diag_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [0:1]  req_valid, f_req_valid;
  logic [0:6]  req_func0, req_func1, f_req_func0, f_req_func1;
  logic [0:35] req_wdata0, req_wdata1, f_req_wdata0, f_req_wdata1;
  logic [0:35] ebus_data_in;
  logic        ebus_par_in;

  logic [0:1]  req_ready, resp_valid, f_req_ready, f_resp_valid;
  logic [0:35] resp_data, f_resp_data, ebus_data_out, f_ebus_data_out;
  logic        resp_par_err, busy, ebus_diag_strobe, ebus_drive;
  logic        f_resp_par_err, f_busy, f_ebus_diag_strobe, f_ebus_drive;
  logic [0:6]  ebus_ds, f_ebus_ds;

  int n_checks = 0;
  int n_errors = 0;
  logic [0:35] exp_rdata;

`ifdef EBUS_DIAG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  ebus_diag_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_func0(req_func0), .req_func1(req_func1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_par_err(resp_par_err), .busy(busy), .ebus_ds(ebus_ds),
    .ebus_diag_strobe(ebus_diag_strobe), .ebus_drive(ebus_drive),
    .ebus_data_out(ebus_data_out), .ebus_data_in(ebus_data_in), .ebus_par_in(ebus_par_in)
  );

  ebus_diag_seq #(.SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid),
    .req_func0(f_req_func0), .req_func1(f_req_func1),
    .req_wdata0(f_req_wdata0), .req_wdata1(f_req_wdata1),
    .req_ready(f_req_ready), .resp_valid(f_resp_valid), .resp_data(f_resp_data),
    .resp_par_err(f_resp_par_err), .busy(f_busy), .ebus_ds(f_ebus_ds),
    .ebus_diag_strobe(f_ebus_diag_strobe), .ebus_drive(f_ebus_drive),
    .ebus_data_out(f_ebus_data_out), .ebus_data_in(ebus_data_in), .ebus_par_in(ebus_par_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit fast, input logic [0:1] want, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if ((fast ? f_req_ready : req_ready) === want) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({req_ready, resp_valid, busy, ebus_ds, ebus_diag_strobe, ebus_drive, resp_par_err} !== '0 ||
        resp_data !== '0 || ebus_data_out !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b busy=%b ds=%o stb=%b drv=%b perr=%b rd=%o do=%o, required all 0",
               req_ready, resp_valid, busy, ebus_ds, ebus_diag_strobe, ebus_drive, resp_par_err,
               resp_data, ebus_data_out);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({f_req_ready, f_resp_valid, f_busy, f_ebus_ds, f_ebus_diag_strobe, f_ebus_drive} !== '0 ||
        f_resp_data !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: fast rdy=%b rv=%b busy=%b ds=%o rd=%o, required all 0",
               f_req_ready, f_resp_valid, f_busy, f_ebus_ds, f_resp_data);
    end
    exp_rdata = '0;
    $display("test_reset done");
  endtask

  task automatic test_write();
    bit ok;
    logic [0:6]  e_ds;
    logic [0:35] e_do;
    logic [0:1]  e_rv;
    logic        e_drv, e_stb, e_busy;
    ebus_data_in = 36'o707070707070;
    req_func0 = 7'o076;
    req_wdata0 = 36'o000000740000;
    req_valid = 2'b10;
    wait_ready(1'b0, 2'b10, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL write_grant: req_ready=%b, required 10 within 8 cycles", req_ready);
    end
    req_valid = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e_ds   = (k <= 8) ? 7'o076 : 7'o000;
      e_drv  = (k <= 8);
      e_do   = (k <= 8) ? 36'o000000740000 : 36'o0;
      e_stb  = (k >= 3 && k <= 6);
      e_busy = (k <= 9);
      e_rv   = (k == 9) ? 2'b10 : 2'b00;
      n_checks++;
      if (ebus_ds !== e_ds || ebus_drive !== e_drv || ebus_data_out !== e_do || ebus_diag_strobe !== e_stb ||
          busy !== e_busy || resp_valid !== e_rv || resp_data !== exp_rdata || resp_par_err !== 1'b0) begin
        n_errors++;
        $display("FAIL write t+%0d: ds=%o drv=%b do=%o stb=%b busy=%b rv=%b rd=%o perr=%b, required ds=%o drv=%b do=%o stb=%b busy=%b rv=%b rd=%o perr=0",
                 k, ebus_ds, ebus_drive, ebus_data_out, ebus_diag_strobe, busy, resp_valid, resp_data, resp_par_err,
                 e_ds, e_drv, e_do, e_stb, e_busy, e_rv, exp_rdata);
      end
    end
    $display("test_write done: func 076 from req0");
  endtask

  task automatic test_read();
    bit ok;
    logic [0:6] e_ds;
    logic [0:1] e_rv;
    ebus_data_in = 36'o123456701234;
    req_func1 = 7'o100;
    req_wdata1 = 36'o111111111111;
    req_valid = 2'b01;
    wait_ready(1'b0, 2'b01, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL read_grant: req_ready=%b, required 01 within 8 cycles", req_ready);
    end
    req_valid = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e_ds = (k <= 8) ? 7'o100 : 7'o000;
      e_rv = (k == 9) ? 2'b01 : 2'b00;
      n_checks++;
      if (ebus_ds !== e_ds || ebus_drive !== 1'b0 || ebus_data_out !== '0 || resp_valid !== e_rv ||
          ebus_diag_strobe !== (k >= 3 && k <= 6)) begin
        n_errors++;
        $display("FAIL read t+%0d: ds=%o drv=%b do=%o rv=%b stb=%b, required ds=%o drv=0 do=0 rv=%b stb=%b",
                 k, ebus_ds, ebus_drive, ebus_data_out, resp_valid, ebus_diag_strobe, e_ds, e_rv, (k >= 3 && k <= 6));
      end
      if (k == 9) begin
        n_checks++;
        if (resp_data !== 36'o123456701234) begin
          n_errors++;
          $display("FAIL read_data: resp_data=%o, required 123456701234", resp_data);
        end
      end
    end
    exp_rdata = 36'o123456701234;
    $display("test_read done: func 100 from req1");
  endtask

  task automatic test_both();
    bit ok;
    int rv0, rv1, rdy1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_rdata = '0;
    req_func0 = 7'o076;
    req_wdata0 = 36'o000000000017;
    req_func1 = 7'o042;
    req_wdata1 = 36'o000000000360;
    req_valid = 2'b11;
    wait_ready(1'b0, 2'b10, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL both_first_grant: req_ready=%b, required 10 (req0 first)", req_ready);
    end
    req_valid = 2'b01;
    rv0 = 0; rv1 = 0; rdy1 = 0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (resp_valid[0] === 1'b1) rv0++;
      if (resp_valid[1] === 1'b1) rv1++;
      if (req_ready[1] === 1'b1) rdy1++;
      if (k == 10) begin
        n_checks++;
        if (req_ready !== 2'b01 || ebus_ds !== 7'o000) begin
          n_errors++;
          $display("FAIL both_second_grant t+10: req_ready=%b ds=%o, required 01 and 000", req_ready, ebus_ds);
        end
        req_valid = 2'b00;
      end
      if (k == 11) begin
        n_checks++;
        if (ebus_ds !== 7'o042 || ebus_data_out !== 36'o000000000360) begin
          n_errors++;
          $display("FAIL both_second_setup t+11: ds=%o do=%o, required 042 and 000000000360", ebus_ds, ebus_data_out);
        end
      end
      if (k == 19) begin
        n_checks++;
        if (resp_valid !== 2'b01) begin
          n_errors++;
          $display("FAIL both_second_done t+19: resp_valid=%b, required 01", resp_valid);
        end
      end
    end
    n_checks++;
    if (rv0 != 1 || rv1 != 1 || rdy1 != 1) begin
      n_errors++;
      $display("FAIL both_counts: resp_valid0=%0d resp_valid1=%0d ready1=%0d, required 1 1 1", rv0, rv1, rdy1);
    end
    $display("test_both done");
  endtask

  task automatic test_fast();
    bit ok;
    ebus_data_in = 36'o777000111222;
    f_req_func0 = 7'o001;
    f_req_wdata0 = 36'o525252525252;
    f_req_valid = 2'b10;
    wait_ready(1'b1, 2'b10, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL fast_write_grant: req_ready=%b, required 10", f_req_ready);
    end
    f_req_valid = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (f_ebus_diag_strobe !== (k == 1) || f_ebus_ds !== ((k == 1) ? 7'o001 : 7'o000) ||
          f_ebus_drive !== (k == 1) || f_resp_valid !== ((k == 2) ? 2'b10 : 2'b00) || f_busy !== (k <= 2)) begin
        n_errors++;
        $display("FAIL fast_write t+%0d: stb=%b ds=%o drv=%b rv=%b busy=%b, required stb=%b drv=%b rv=%b busy=%b",
                 k, f_ebus_diag_strobe, f_ebus_ds, f_ebus_drive, f_resp_valid, f_busy,
                 (k == 1), (k == 1), (k == 2) ? 2'b10 : 2'b00, (k <= 2));
      end
    end
    f_req_func1 = 7'o177;
    f_req_valid = 2'b01;
    wait_ready(1'b1, 2'b01, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL fast_read_grant: req_ready=%b, required 01", f_req_ready);
    end
    f_req_valid = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (f_ebus_diag_strobe !== (k == 1) || f_ebus_drive !== 1'b0 || f_resp_valid !== ((k == 2) ? 2'b01 : 2'b00) ||
          (k >= 2 && f_resp_data !== 36'o777000111222)) begin
        n_errors++;
        $display("FAIL fast_read t+%0d: stb=%b drv=%b rv=%b rd=%o, required stb=%b drv=0 rv=%b rd=777000111222 from t+2",
                 k, f_ebus_diag_strobe, f_ebus_drive, f_resp_valid, f_resp_data, (k == 1), (k == 2) ? 2'b01 : 2'b00);
      end
    end
    $display("test_fast done");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rv_seen;
    req_func0 = 7'o076;
    req_wdata0 = 36'o000000740000;
    req_valid = 2'b10;
    wait_ready(1'b0, 2'b10, ok);
    req_valid = 2'b00;
    for (int k = 1; k <= 4; k++) tick();
    n_checks++;
    if (!ok || ebus_diag_strobe !== 1'b1 || ebus_drive !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_pre: grant=%b stb=%b drv=%b, required grant 1 stb 1 drv 1", ok, ebus_diag_strobe, ebus_drive);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ebus_ds !== 7'o000 || ebus_diag_strobe !== 1'b0 || ebus_drive !== 1'b0 || busy !== 1'b0 || ebus_data_out !== '0) begin
      n_errors++;
      $display("FAIL rstmid_async: ds=%o stb=%b drv=%b busy=%b do=%o, required all 0 before any clock edge",
               ebus_ds, ebus_diag_strobe, ebus_drive, busy, ebus_data_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_rdata = '0;
    rv_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (resp_valid !== 2'b00) rv_seen++;
    end
    n_checks++;
    if (rv_seen != 0) begin
      n_errors++;
      $display("FAIL rstmid_no_resp: resp_valid seen %0d cycles, required 0", rv_seen);
    end
    ebus_data_in = 36'o012345670123;
    req_func1 = 7'o100;
    req_valid = 2'b01;
    wait_ready(1'b0, 2'b01, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rstmid_regrant: req_ready=%b, required 01", req_ready);
    end
    req_valid = 2'b00;
    for (int k = 1; k <= 9; k++) tick();
    n_checks++;
    if (resp_valid !== 2'b01 || resp_data !== 36'o012345670123) begin
      n_errors++;
      $display("FAIL rstmid_after: rv=%b rd=%o, required 01 and 012345670123", resp_valid, resp_data);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_parity();
    bit ok;
    logic e_err;
    for (int p = 0; p < 2; p++) begin
      ebus_data_in = 36'o000000000001;
      ebus_par_in = (p == 1);
      req_func0 = 7'o100;
      req_valid = 2'b10;
      wait_ready(1'b0, 2'b10, ok);
      req_valid = 2'b00;
      for (int k = 1; k <= 9; k++) tick();
      e_err = PAR_EN & (p == 1);
      n_checks++;
      if (!ok || resp_valid !== 2'b10 || resp_par_err !== e_err) begin
        n_errors++;
        $display("FAIL parity par_in=%0d: grant=%b rv=%b perr=%b, required grant 1 rv 10 perr %b",
                 p, ok, resp_valid, resp_par_err, e_err);
      end
      tick();
    end
    ebus_par_in = 1'b0;
    $display("test_parity done (parity enabled=%0d)", PAR_EN);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; req_func0 = '0; req_func1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    f_req_valid = 2'b00; f_req_func0 = '0; f_req_func1 = '0; f_req_wdata0 = '0; f_req_wdata1 = '0;
    ebus_data_in = '0;
    ebus_par_in = 1'b0;
    exp_rdata = '0;
    test_reset();
    test_write();
    test_read();
    test_both();
    test_fast();
    test_reset_mid();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
